// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NREQ requesters,
// with a single registered result slot that can be refilled while it drains.
module add_arbiter #(
  parameter  int NREQ  = 3,
  parameter  int WIDTH = 4,
  localparam int IDW   = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_carry
);

  logic [NREQ-1:0][WIDTH-1:0] a_arr, b_arr;
  logic [IDW-1:0]             ptr;
  logic [IDW-1:0]             gnt_id;
  logic [NREQ-1:0]            gnt;
  logic                       can_accept;
  logic                       xfer;
  logic [WIDTH:0]             sum_w;

  assign a_arr      = req_a;
  assign b_arr      = req_b;
  assign can_accept = !rsp_valid || rsp_ready;

  // Search upward from ptr with wrap; the first valid requester wins.
  always_comb begin
    logic           found;
    logic [IDW:0]   s;
    logic [IDW-1:0] idx;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    s      = '0;
    idx    = '0;
    if (can_accept && !reset) begin
      for (int k = 0; k < NREQ; k++) begin
        s = {1'b0, ptr} + (IDW+1)'(k);
        if (s >= (IDW+1)'(NREQ)) s = s - (IDW+1)'(NREQ);
        idx = s[IDW-1:0];
        if (!found && req_valid[idx]) begin
          found       = 1'b1;
          gnt[idx]    = 1'b1;
          gnt_id      = idx;
        end
      end
    end
  end

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign sum_w     = {1'b0, a_arr[gnt_id]} + {1'b0, b_arr[gnt_id]};

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      // A same-edge drain is implied by can_accept, so the slot is simply refilled.
      rsp_valid <= 1'b1;
      {rsp_carry, rsp_sum} <= sum_w;
      rsp_id    <= gnt_id;
      ptr       <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Randomized + directed bench for add_arbiter: a queue-based reference model
// predicts grants and results; a negedge monitor compares against the DUT.
module tb_add_arbiter;
  localparam int NREQ  = 3;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;

  add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry));

  always #5 clk = ~clk;

  typedef struct { int id; int sum; int carry; } exp_t;

  exp_t q[$];
  int   mptr      = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   gnt_s     = -1;
  bit   rst_s     = 1'b0;
  bit   after_rst = 1'b0;
  exp_t pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model + monitor: inputs are stable here, so snapshot what the next edge will do.
  always @(negedge clk) begin
    int              g, idx, a, b, s;
    logic [NREQ-1:0] eg;
    bit              ca;
    ca = (q.size() == 0) || rsp_ready;
    g  = -1;
    if (ca && !reset)
      for (int k = 0; k < NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(eg));
    check("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
    if (after_rst) begin
      check("reset_sum",   32'(rsp_sum),   0);
      check("reset_id",    32'(rsp_id),    0);
      check("reset_carry", 32'(rsp_carry), 0);
    end
    if (rsp_valid === 1'b1 && q.size() != 0) begin
      check("rsp_id",    32'(rsp_id),    q[0].id);
      check("rsp_sum",   32'(rsp_sum),   q[0].sum);
      check("rsp_carry", 32'(rsp_carry), q[0].carry);
      if (rsp_ready) void'(q.pop_front());
    end
    if (g >= 0) begin
      a = int'(req_a[g*WIDTH +: WIDTH]);
      b = int'(req_b[g*WIDTH +: WIDTH]);
      s = a + b;
      pend.id    = g;
      pend.sum   = s % (1 << WIDTH);
      pend.carry = s >> WIDTH;
    end
    gnt_s = g;
    rst_s = reset;
  end

  always @(posedge clk) begin
    if (rst_s) begin
      q.delete();
      mptr      = 0;
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (gnt_s >= 0) begin
        q.push_back(pend);
        mptr = (gnt_s + 1) % NREQ;
      end
    end
  end

  task automatic cyc(input bit r, input logic [NREQ-1:0] v, input bit rr);
    reset     = r;
    req_valid = v;
    rsp_ready = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    req_a = NREQ*WIDTH'($urandom);
    req_b = NREQ*WIDTH'($urandom);
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b1; req_a = '0; req_b = '0;
    cyc(1, 3'b000, 1); cyc(1, 3'b000, 1);
    // single requester, no carry then carry
    req_a[0*WIDTH +: WIDTH] = 4'h7; req_b[0*WIDTH +: WIDTH] = 4'h5;
    cyc(0, 3'b001, 1); cyc(0, 3'b000, 1);
    req_a[1*WIDTH +: WIDTH] = 4'hF; req_b[1*WIDTH +: WIDTH] = 4'h1;
    cyc(0, 3'b010, 1); cyc(0, 3'b000, 1);
    // all requesting after reset: full-throughput rotation
    cyc(1, 3'b000, 1);
    for (int i = 0; i < 4; i++) begin rand_ops(); cyc(0, 3'b111, 1); end
    // backpressure then release
    for (int i = 0; i < 4; i++) begin rand_ops(); cyc(0, 3'b111, 0); end
    rand_ops(); cyc(0, 3'b111, 1); cyc(0, 3'b000, 1);
    // pointer wrap
    cyc(1, 3'b000, 1);
    rand_ops(); cyc(0, 3'b100, 1);
    rand_ops(); cyc(0, 3'b011, 1); rand_ops(); cyc(0, 3'b011, 1); cyc(0, 3'b000, 1);
    // reset during a grant with a result pending
    rand_ops(); cyc(0, 3'b001, 1);
    rand_ops(); cyc(1, 3'b010, 1);
    rand_ops(); cyc(0, 3'b011, 1); cyc(0, 3'b011, 1); cyc(0, 3'b000, 1);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      cyc(($urandom_range(0, 49) == 0), NREQ'($urandom), ($urandom_range(0, 3) != 0));
    end
    cyc(0, 3'b000, 1); cyc(0, 3'b000, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
